// File: rtl/cba_pkg.sv
// Shared constants and FSM state type for the nibble-serial carry-bypass adder sequencer.
package cba_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/carry_bypass_4.sv
// Combinational 4-bit carry-bypass slice: ripple carry, skipped straight to cout when all bits propagate.
module carry_bypass_4
  import cba_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] s,
  output logic             cout,
  output logic             p_all
);

  logic [NIB_W-1:0] p;
  logic [NIB_W-1:0] g;
  logic             c1;
  logic             c2;
  logic             c3;
  logic             c4;

  assign p = a ^ b;
  assign g = a & b;

  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & c1);
  assign c3 = g[2] | (p[2] & c2);
  assign c4 = g[3] | (p[3] & c3);

  assign s     = p ^ {c3, c2, c1, cin};
  assign p_all = &p;
  // With every bit propagating the ripple result equals cin; take the short path.
  assign cout  = p_all ? cin : c4;

endmodule

// File: rtl/cba_seq_ctrl.sv
// Sequences one shared 4-bit carry-bypass slice over WIDTH-bit operands, one nibble per cycle.
// Optional subtract mode (sub port, A-B via ~B plus carry-in 1) enabled by defining CBA_SUB_EN.
module cba_seq_ctrl
  import cba_pkg::*;
#(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned CNT_W = $clog2(WIDTH / 4 + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
`ifdef CBA_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic [CNT_W-1:0] byp_cnt,
  output logic             busy
);

  localparam int unsigned NIB   = WIDTH / NIB_W;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] byp_q, byp_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] b_in;
  logic             carry_in;
  logic [NIB_W-1:0] slice_s;
  logic             slice_cout;
  logic             slice_p_all;

  // Operand conditioning at accept; subtract is A + ~B + 1.
`ifdef CBA_SUB_EN
  assign b_in     = sub ? ~B : B;
  assign carry_in = sub | cin;
`else
  assign b_in     = B;
  assign carry_in = cin;
`endif

  carry_bypass_4 u_slice (
    .a     (a_q[idx_q*NIB_W +: NIB_W]),
    .b     (b_q[idx_q*NIB_W +: NIB_W]),
    .cin   (carry_q),
    .s     (slice_s),
    .cout  (slice_cout),
    .p_all (slice_p_all)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    s_d         = s_q;
    cout_d      = cout_q;
    byp_d       = byp_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d    = RUN;
          a_d        = A;
          b_d        = b_in;
          carry_d    = carry_in;
          idx_d      = '0;
          s_d        = '0;
          cout_d     = 1'b0;
          byp_d      = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        s_d[idx_q*NIB_W +: NIB_W] = slice_s;
        carry_d = slice_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (slice_p_all) begin
          byp_d = byp_q + CNT_W'(1);
        end
        if (idx_q == IDX_W'(NIB - 1)) begin
          state_d     = DONE;
          cout_d      = slice_cout;
          out_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      byp_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      s_q         <= s_d;
      cout_q      <= cout_d;
      byp_q       <= byp_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign S         = s_q;
  assign Cout      = cout_q;
  assign byp_cnt   = byp_q;
  assign busy      = busy_q;

endmodule
